// File: rtl/counter_period_averager.sv
// counter_period_averager
//   Measures the period between counter_reset pulses (as published on
//   last_counter by the counter-delayed trigger stage), keeps a sliding-window
//   mean over the last 2^AVG_LOG2 accepted periods, rejects outliers, and
//   drives the mean out as reference_counter for the trigger stage.
//
// Ports:
//   clk               in   system clock
//   reset             in   synchronous active-high reset
//   enable            in   block active; low behaves like reset
//   flush             in   one-cycle pulse: empty the window, keep counters
//   counter_reset     in   period pulse shared with the trigger stage
//   last_counter      in   full-period count, valid the cycle after the edge
//   tolerance         in   max |sample - mean| accepted when mean valid; 0 = off
//   reference_counter out  window mean, 0 while not valid
//   average_valid     out  window full, mean usable
//   rejected_count    out  saturating count of rejected samples
//   sample_count      out  saturating count of accepted samples
//
// Pipeline (E = edge cycle):
//   E+1 capture last_counter, E+2 accept/reject decision,
//   E+3 window/sum/fill update, E+4 output mean update.
module counter_period_averager #(
    parameter int unsigned COUNTER_WIDTH = 32,
    parameter int unsigned AVG_LOG2      = 3,
    parameter int unsigned MAX_REJECT    = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     flush,
    input  logic                     counter_reset,
    input  logic [COUNTER_WIDTH-1:0] last_counter,
    input  logic [COUNTER_WIDTH-1:0] tolerance,
    output logic [COUNTER_WIDTH-1:0] reference_counter,
    output logic                     average_valid,
    output logic [15:0]              rejected_count,
    output logic [15:0]              sample_count
);

    localparam int unsigned DEPTH  = 1 << AVG_LOG2;
    localparam int unsigned SUM_W  = COUNTER_WIDTH + AVG_LOG2;
    localparam int unsigned PTR_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int unsigned FILL_W = AVG_LOG2 + 1;
    localparam int unsigned REJ_W  = $clog2(MAX_REJECT + 1);

    // Edge detect
    logic prev_cr;
    logic pulse_edge;

    // Capture stage
    logic                     cap_pend;
    logic                     smp_valid;
    logic [COUNTER_WIDTH-1:0] smp_data;
    logic                     first_pending;

    // Decision stage
    logic                     acc_valid;
    logic [COUNTER_WIDTH-1:0] acc_data;
    logic                     force_flush;
    logic [REJ_W-1:0]         reject_run;

    // Window
    logic [COUNTER_WIDTH-1:0] window_mem [DEPTH];
    logic [PTR_W-1:0]         wr_ptr;
    logic [FILL_W-1:0]        fill;
    logic [SUM_W-1:0]         sum;
    logic                     upd_pend;

    // Combinational helpers
    logic [COUNTER_WIDTH-1:0] abs_diff;
    logic                     is_outlier;
    logic                     window_full;
    logic [COUNTER_WIDTH-1:0] oldest;
    logic [SUM_W-1:0]         sum_next;
    logic [FILL_W-1:0]        fill_next;
    logic [PTR_W-1:0]         ptr_next;
    logic [COUNTER_WIDTH-1:0] mean;
    logic                     do_flush;

    always_comb begin
        pulse_edge = counter_reset & ~prev_cr;

        // Larger minus smaller so the distance never wraps.
        if (smp_data >= reference_counter)
            abs_diff = smp_data - reference_counter;
        else
            abs_diff = reference_counter - smp_data;

        // Mean used here is whatever is registered now, even if an
        // accepted sample is still travelling down the pipeline.
        is_outlier = average_valid && (tolerance != '0) && (abs_diff > tolerance);

        window_full = (fill == FILL_W'(DEPTH));

        // Until the window is full the slot being overwritten has never been
        // counted in the sum, so nothing is subtracted and no clear is needed.
        oldest    = window_full ? window_mem[wr_ptr] : '0;
        sum_next  = sum + SUM_W'(acc_data) - SUM_W'(oldest);
        fill_next = window_full ? fill : fill + FILL_W'(1);
        ptr_next  = (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);

        mean = COUNTER_WIDTH'(sum >> AVG_LOG2);

        // External flush and the reject-run flush share one path.
        do_flush = flush | force_flush;
    end

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            prev_cr           <= 1'b0;
            cap_pend          <= 1'b0;
            smp_valid         <= 1'b0;
            smp_data          <= '0;
            first_pending     <= 1'b1;
            acc_valid         <= 1'b0;
            acc_data          <= '0;
            force_flush       <= 1'b0;
            reject_run        <= '0;
            wr_ptr            <= '0;
            fill              <= '0;
            sum               <= '0;
            upd_pend          <= 1'b0;
            reference_counter <= '0;
            average_valid     <= 1'b0;
            rejected_count    <= '0;
            sample_count      <= '0;
        end else if (do_flush) begin
            // Edge history keeps tracking so a pulse high across the flush
            // is not re-detected; anything in flight is dropped.
            prev_cr           <= counter_reset;
            cap_pend          <= 1'b0;
            smp_valid         <= 1'b0;
            first_pending     <= 1'b1;
            acc_valid         <= 1'b0;
            force_flush       <= 1'b0;
            reject_run        <= '0;
            wr_ptr            <= '0;
            fill              <= '0;
            sum               <= '0;
            upd_pend          <= 1'b0;
            reference_counter <= '0;
            average_valid     <= 1'b0;
        end else begin
            prev_cr  <= counter_reset;

            // E -> E+1: last_counter becomes valid the cycle after the edge.
            cap_pend  <= pulse_edge;
            smp_valid <= cap_pend;
            if (cap_pend)
                smp_data <= last_counter;

            // E+2: discard / reject / accept.
            acc_valid   <= 1'b0;
            force_flush <= 1'b0;
            if (smp_valid) begin
                if (first_pending) begin
                    first_pending <= 1'b0;
                end else if (smp_data != '0) begin
                    if (is_outlier) begin
                        if (rejected_count != '1)
                            rejected_count <= rejected_count + 16'd1;
                        if (reject_run == REJ_W'(MAX_REJECT - 1))
                            force_flush <= 1'b1;
                        reject_run <= reject_run + REJ_W'(1);
                    end else begin
                        reject_run <= '0;
                        acc_valid  <= 1'b1;
                        acc_data   <= smp_data;
                    end
                end
            end

            // E+3: window update.
            upd_pend <= acc_valid;
            if (acc_valid) begin
                sum    <= sum_next;
                fill   <= fill_next;
                wr_ptr <= ptr_next;
                if (sample_count != '1)
                    sample_count <= sample_count + 16'd1;
            end

            // E+4: publish the mean.
            if (upd_pend) begin
                average_valid     <= window_full;
                reference_counter <= window_full ? mean : '0;
            end
        end
    end

    // Sample storage carries no reset; stale contents are never summed.
    always_ff @(posedge clk) begin
        if (!reset && enable && !do_flush && acc_valid)
            window_mem[wr_ptr] <= acc_data;
    end

endmodule

// File: tb/tb_counter_period_averager.sv
// Testbench for counter_period_averager.
// Stimulus pushes the expected output state for every counter_reset pulse;
// an independent monitor spots each pulse edge, waits for the pipeline to
// settle and compares the DUT outputs against the queued expectation.
module tb_counter_period_averager;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        flush;
    logic        counter_reset;
    logic [31:0] last_counter;
    logic [31:0] tolerance;
    logic [31:0] reference_counter;
    logic        average_valid;
    logic [15:0] rejected_count;
    logic [15:0] sample_count;

    always #5 clk = ~clk;

    counter_period_averager #(
        .COUNTER_WIDTH(32),
        .AVG_LOG2(3),
        .MAX_REJECT(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .flush(flush),
        .counter_reset(counter_reset),
        .last_counter(last_counter),
        .tolerance(tolerance),
        .reference_counter(reference_counter),
        .average_valid(average_valid),
        .rejected_count(rejected_count),
        .sample_count(sample_count)
    );

    typedef struct {
        logic [31:0] ref_v;
        logic        valid;
        logic [15:0] sc;
        logic [15:0] rc;
        int          id;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int          pulse_id = 0;
    logic        mon_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [31:0] r, input logic v,
                                 input int sc, input int rc);
        check({tag, ".ref"},     reference_counter,     r);
        check({tag, ".valid"},   32'(average_valid),    32'(v));
        check({tag, ".samples"}, 32'(sample_count),     32'(sc));
        check({tag, ".rejects"}, 32'(rejected_count),   32'(rc));
    endtask

    // One period pulse, 8 cycles apart, with expected settled outputs.
    task automatic pulse(input logic [31:0] v, input logic [31:0] r, input logic vld,
                         input int sc, input int rc);
        exp_t e;
        e.ref_v = r;
        e.valid = vld;
        e.sc    = 16'(sc);
        e.rc    = 16'(rc);
        e.id    = pulse_id;
        pulse_id++;
        exp_q.push_back(e);
        counter_reset = 1'b1;
        last_counter  = v;
        @(negedge clk);
        counter_reset = 1'b0;
        repeat (7) @(negedge clk);
    endtask

    task automatic do_flush(input int sc, input int rc);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check_outputs("after_flush", 32'd0, 1'b0, sc, rc);
    endtask

    // Monitor: sees the edge exactly as the DUT does, checks after settling.
    initial begin
        exp_t e;
        logic rise;
        forever begin
            @(posedge clk);
            rise     = counter_reset && !mon_prev;
            mon_prev = counter_reset;
            if (rise) begin
                repeat (6) @(negedge clk);
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL scoreboard: got an edge with no expected entry, required one");
                end else begin
                    e = exp_q.pop_front();
                    check_outputs($sformatf("pulse%0d", e.id), e.ref_v, e.valid,
                                  int'(e.sc), int'(e.rc));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000 ns, required earlier");
        $fatal(1);
    end

    initial begin
        reset         = 1'b1;
        enable        = 1'b1;
        flush         = 1'b0;
        counter_reset = 1'b0;
        last_counter  = '0;
        tolerance     = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_outputs("reset", 32'd0, 1'b0, 0, 0);

        // Fill with constant 1000; first sample discarded.
        pulse(32'd1000, 32'd0, 1'b0, 0, 0);
        for (int k = 1; k <= 8; k++)
            pulse(32'd1000, (k == 8) ? 32'd1000 : 32'd0, k == 8, k, 0);

        // Truncating mean: 1000..1007 sums to 8028 -> 1003.
        do_flush(8, 0);
        pulse(32'd1000, 32'd0, 1'b0, 8, 0);
        for (int k = 0; k < 8; k++)
            pulse(32'd1000 + 32'(k), (k == 7) ? 32'd1003 : 32'd0, k == 7, 9 + k, 0);

        // Outliers against a window of 1000 with tolerance 50.
        do_flush(16, 0);
        pulse(32'd1000, 32'd0, 1'b0, 16, 0);
        for (int k = 1; k <= 8; k++)
            pulse(32'd1000, (k == 8) ? 32'd1000 : 32'd0, k == 8, 16 + k, 0);
        tolerance = 32'd50;
        pulse(32'd2000, 32'd1000, 1'b1, 24, 1);  // rejected
        pulse(32'd1050, 32'd1006, 1'b1, 25, 1);  // |diff|=50 accepted, 8050>>3
        pulse(32'd1057, 32'd1006, 1'b1, 25, 2);  // |diff|=51 rejected
        pulse(32'd1040, 32'd1011, 1'b1, 26, 2);  // accepted, 8090>>3

        // Period change: four rejects force a flush.
        pulse(32'd2000, 32'd1011, 1'b1, 26, 3);
        pulse(32'd2000, 32'd1011, 1'b1, 26, 4);
        pulse(32'd2000, 32'd1011, 1'b1, 26, 5);
        pulse(32'd2000, 32'd0,    1'b0, 26, 6);
        pulse(32'd2000, 32'd0,    1'b0, 26, 6);  // discarded as first
        for (int k = 1; k <= 8; k++)
            pulse(32'd2000, (k == 8) ? 32'd2000 : 32'd0, k == 8, 26 + k, 6);

        // Reset mid-fill.
        do_flush(34, 6);
        pulse(32'd1000, 32'd0, 1'b0, 34, 6);
        for (int k = 1; k <= 5; k++)
            pulse(32'd1000, 32'd0, 1'b0, 34 + k, 6);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_outputs("mid_reset", 32'd0, 1'b0, 0, 0);
        pulse(32'd1000, 32'd0, 1'b0, 0, 0);
        for (int k = 1; k <= 8; k++)
            pulse(32'd1000, (k == 8) ? 32'd1000 : 32'd0, k == 8, k, 0);

        // enable low for one cycle, then wrap-around with alternating samples.
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        check_outputs("enable_low", 32'd0, 1'b0, 0, 0);
        tolerance = '0;
        pulse(32'd1000, 32'd0, 1'b0, 0, 0);
        for (int k = 1; k <= 20; k++)
            pulse((k % 2 == 1) ? 32'd1000 : 32'd1016,
                  (k >= 8) ? 32'd1008 : 32'd0, k >= 8, k, 0);

        for (int i = 0; i < 50 && exp_q.size() != 0; i++)
            @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/counter_period_averager.md
Name: counter_period_averager

Overview:
- Upstream companion of the counter-delayed trigger stage. Produces its reference_counter input.
- Watches the same counter_reset pulse and captures the last_counter value that the trigger stage publishes after each pulse.
- Keeps a sliding-window mean over the last 2^AVG_LOG2 accepted periods and rejects outlier periods.
- Drives a stable reference period so the trigger can fire trigger_presamples ahead of the next pulse.

Parameters:
- COUNTER_WIDTH, 32, width of last_counter, reference_counter and tolerance.
- AVG_LOG2, 3, log2 of window depth (window = 8 samples); legal range 0..4.
- MAX_REJECT, 4, number of consecutive rejects that forces a flush and refill.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  block active; 0 acts as reset.
- flush  in  1  single-cycle pulse; clears window, keeps counters.
- counter_reset  in  1  same period pulse that feeds the trigger stage.
- last_counter  in  COUNTER_WIDTH  full-period count from the trigger stage; valid 1 cycle after the counter_reset rising edge.
- tolerance  in  COUNTER_WIDTH  max |sample - mean| accepted once the mean is valid; 0 disables rejection.
- reference_counter  out  COUNTER_WIDTH  window mean; 0 while not valid.
- average_valid  out  1  window full, mean usable.
- rejected_count  out  16  saturating count of rejected samples.
- sample_count  out  16  saturating count of accepted samples.

Behaviour:
- Reset, or enable=0: all outputs 0, window cleared, fill count 0, edge-detect history cleared. No captures occur in this state.
- Edge detect:
  - Edge cycle E is a cycle where counter_reset=1 and the registered previous value was 0.
  - The registered previous value is 0 after reset, so a pulse already high at enable counts as an edge.
- Pipeline timing:
  - E+1: last_counter is registered into the sample register.
  - E+2: accept/reject decision is registered.
  - E+3: buffer, running sum and fill count are updated.
  - E+4: reference_counter and average_valid are updated.
- Discard rules:
  - The first captured sample after reset, enable rise or flush is discarded; it measures a partial period. No count changes.
  - A sample equal to 0 is discarded silently.
- Reject rule:
  - Applies only when average_valid=1 and tolerance!=0.
  - Reject if |sample - reference_counter| > tolerance. Compute with unsigned subtraction of the larger minus the smaller; no wrap.
  - On reject: rejected_count += 1 (saturate at 0xFFFF), consecutive-reject counter += 1. Window is untouched.
  - On accept: consecutive-reject counter = 0.
  - When the consecutive-reject counter reaches MAX_REJECT, act as a flush in the E+3 cycle. The triggering sample is not stored, and the next captured sample is again discarded as first.
- Window: circular buffer of 2^AVG_LOG2 entries with a wrapping write pointer.
  - Running sum is COUNTER_WIDTH+AVG_LOG2 bits. Update: sum <= sum + new - oldest.
  - oldest is 0 while fill count < depth, so the buffer never needs clearing.
- Fill and output:
  - Fill count saturates at depth. average_valid=1 once fill count = depth.
  - reference_counter = sum >> AVG_LOG2 (truncating) when valid, else 0. Holds value between updates.
- flush:
  - Clears sum, fill count, pointer, average_valid, reference_counter and the consecutive-reject counter.
  - Re-arms the first-sample discard. Keeps rejected_count and sample_count.
  - Takes effect the next cycle; a sample in flight in the pipeline that cycle is dropped.
- Simultaneous events: reset beats enable=0, which beats flush, which beats a sample update.
- Back-to-back edges: the pipeline accepts one edge every 2 cycles, which is the minimum physical spacing. The reject decision uses the mean registered at E+2, even if an update is still in flight.

Test Plan:
- Fill: depth 8, tolerance 0, nine pulses with last_counter=1000 (first is discarded) -> average_valid rises 4 cycles after the 9th edge; reference_counter=1000; sample_count=8.
- Truncating mean: after the discard, accepted samples 1000..1007 -> sum 8028, reference_counter=1003 (8028>>3).
- Outlier: valid window of 1000, tolerance=50, one sample 2000 -> rejected_count=1, reference_counter stays 1000; the next sample 1040 is accepted; a sample of 1050 (|diff|=50) is accepted.
- Period change: four consecutive samples of 2000 with tolerance 50 -> flush on the 4th; average_valid=0, reference_counter=0. The next 2000 is discarded, then 8 more give reference_counter=2000.
- Reset and enable:
  - reset asserted mid-fill after 5 samples -> all outputs 0 the next cycle; a full refill with discard is required.
  - enable=0 for one cycle -> same result.
- Wrap-around: 20 samples alternating 1000/1016 with tolerance 0 -> sum never overflows; reference_counter=1008 after every update once full.
